// File: rtl/cpu_hatch_pkg.sv
// cpu_hatch_pkg: shared widths, default NOP word and loader state encoding
package cpu_hatch_pkg;
   localparam int INSTR_W = 48;
   localparam int INSTR_BYTES = 6;
   localparam logic [INSTR_W-1:0] NOP_DEFAULT = '0;
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE} ld_state_t;
endpackage

// File: rtl/cpu_hatch_if.sv
// cpu_hatch_if: fetch read port and byte-stream loader port; CPU_HATCH_CHECKSUM_EN adds ld_checksum
interface cpu_hatch_if import cpu_hatch_pkg::*; #(parameter int ADDR_W = 10);
   logic [31:0] hatch_address;
   logic [INSTR_W-1:0] hatch_instruction;
   logic ld_valid, ld_ready, ld_last, loading, ld_error;
   logic [7:0] ld_byte;
   logic [ADDR_W:0] ld_count;
`ifdef CPU_HATCH_CHECKSUM_EN
   logic [7:0] ld_checksum;
   modport slave (input hatch_address, ld_valid, ld_byte, ld_last,
                  output hatch_instruction, ld_ready, loading, ld_count, ld_error, ld_checksum);
   modport master (output hatch_address, ld_valid, ld_byte, ld_last,
                   input hatch_instruction, ld_ready, loading, ld_count, ld_error, ld_checksum);
`else
   modport slave (input hatch_address, ld_valid, ld_byte, ld_last,
                  output hatch_instruction, ld_ready, loading, ld_count, ld_error);
   modport master (output hatch_address, ld_valid, ld_byte, ld_last,
                   input hatch_instruction, ld_ready, loading, ld_count, ld_error);
`endif
endinterface

// File: rtl/cpu_hatch_ram.sv
// cpu_hatch_ram: 2^ADDR_W x 48 instruction store, one sync write port, one registered read port
module cpu_hatch_ram import cpu_hatch_pkg::*; #(parameter int ADDR_W = 10) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);
   logic [INSTR_W-1:0] mem [2**ADDR_W];
   // write and registered read; a same-address read returns the old contents
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/cpu_hatch.sv
// cpu_hatch: fetch instruction store with byte-stream loader; CPU_HATCH_CHECKSUM_EN adds ld_checksum
module cpu_hatch import cpu_hatch_pkg::*; #(
   parameter int ADDR_W = 10,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_DEFAULT
) (
   input logic clk,
   input logic rst_b,
   cpu_hatch_if.slave bus
);
   ld_state_t state;
   logic [INSTR_BYTES-1:0][7:0] word;
   logic [2:0] bcnt;
   logic last_f, nop_q, xfer, full;
   logic [INSTR_W-1:0] rdata;
   assign xfer = bus.ld_valid && bus.ld_ready;
   assign full = bus.ld_count[ADDR_W];
   assign bus.hatch_instruction = nop_q ? NOP_WORD : rdata;
   cpu_hatch_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk,
      .we(state == WRITE && !full),
      .waddr(bus.ld_count[ADDR_W-1:0]),
      .wdata(word),
      .raddr(bus.hatch_address[ADDR_W-1:0]),
      .rdata
   );
   // mask the read result for out-of-range addresses and while a load runs
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) nop_q <= 1'b1;
      else nop_q <= bus.loading || (bus.hatch_address[31:ADDR_W] != '0);
   // loader FSM: assembles bytes into words and commits them; ld_count doubles as write pointer
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
         bcnt <= '0;
         last_f <= 1'b0;
         word <= '0;
         bus.loading <= 1'b0;
         bus.ld_ready <= 1'b1;
         bus.ld_count <= '0;
         bus.ld_error <= 1'b0;
      end else case (state)
         IDLE: if (xfer) begin
            word <= {bus.ld_byte, {(INSTR_W-8){1'b0}}};
            bcnt <= 3'd1;
            last_f <= bus.ld_last;
            bus.ld_count <= '0;
            bus.ld_error <= bus.ld_last;
            bus.loading <= 1'b1;
            bus.ld_ready <= !bus.ld_last;
            state <= bus.ld_last ? WRITE : COLLECT;
         end
         COLLECT: if (xfer) begin
            word[3'(INSTR_BYTES-1) - bcnt] <= bus.ld_byte;
            bcnt <= bcnt + 3'd1;
            last_f <= bus.ld_last;
            if (bus.ld_last && bcnt != 3'(INSTR_BYTES-1)) bus.ld_error <= 1'b1;
            if (bus.ld_last || bcnt == 3'(INSTR_BYTES-1)) begin
               bus.ld_ready <= 1'b0;
               state <= WRITE;
            end
         end
         WRITE: begin
            if (full) bus.ld_error <= 1'b1;
            else bus.ld_count <= bus.ld_count + (ADDR_W+1)'(1);
            word <= '0;
            bcnt <= '0;
            bus.ld_ready <= 1'b1;
            bus.loading <= !last_f;
            state <= last_f ? IDLE : COLLECT;
         end
         default: state <= IDLE;
      endcase
   end
`ifdef CPU_HATCH_CHECKSUM_EN
   // running byte sum, restarted by the first transfer of each load
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) bus.ld_checksum <= '0;
      else if (xfer) bus.ld_checksum <= (state == IDLE ? 8'h00 : bus.ld_checksum) + bus.ld_byte;
`endif
endmodule

// File: tb/tb_cpu_hatch.sv
// tb_cpu_hatch: randomized loader/fetch bench against a word-level store model
module tb_cpu_hatch;
   import cpu_hatch_pkg::*;
   localparam int AW = 10;
   localparam int DEPTH = 1 << AW;
   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [47:0] model [DEPTH];
   bit prev_loading = 1'b0;
   cpu_hatch_if #(.ADDR_W(AW)) bus ();
   cpu_hatch #(.ADDR_W(AW)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   // a word is 6 consecutive bytes, big-endian, short final word zero-padded
   function automatic void fill(input logic [7:0] b [$], input int nmax);
      logic [47:0] v;
      for (int w = 0; w < nmax && w * 6 < b.size(); w++) begin
         v = '0;
         for (int k = 0; k < 6; k++) v = {v[39:0], (w * 6 + k < b.size()) ? b[w * 6 + k] : 8'h00};
         model[w] = v;
      end
   endfunction
   always @(negedge clk) begin
      if (prev_loading) chk("nop_during_load", bus.hatch_instruction, 48'h0);
      prev_loading = bus.loading;
   end
   task automatic send(input logic [7:0] b [$], input bit gaps, input bit last);
      for (int i = 0; i < b.size(); i++) begin
         int t;
         if (gaps) begin
            bus.ld_valid = 1'b0;
            repeat ($urandom_range(2)) @(negedge clk);
         end
         bus.hatch_address = $urandom;
         bus.ld_valid = 1'b1;
         bus.ld_byte = b[i];
         bus.ld_last = last && (i == b.size() - 1);
         t = 0;
         while (!bus.ld_ready && t < 4) begin
            @(negedge clk);
            t++;
         end
         if (t >= 4) chk("ready_timeout", 1, 0);
         if (!gaps) chk("ready_gap", t, (i > 0 && i % 6 == 0) ? 1 : 0);
         @(negedge clk);
      end
      bus.ld_valid = 1'b0;
      bus.ld_last = 1'b0;
   endtask
   task automatic load(input logic [7:0] b [$], input bit gaps);
      int nw, t;
      logic [7:0] sum;
      nw = (b.size() + 5) / 6;
      sum = 8'h00;
      foreach (b[i]) sum += b[i];
      fill(b, DEPTH);
      send(b, gaps, 1'b1);
      t = 0;
      while (bus.loading && t < 8) begin
         @(negedge clk);
         t++;
      end
      chk("load_end_cycles", t, 1);
      chk("ld_count", bus.ld_count, (nw > DEPTH) ? DEPTH : nw);
      chk("ld_error", bus.ld_error, ((b.size() % 6) != 0) || (nw > DEPTH));
      chk("ld_ready_idle", bus.ld_ready, 1);
`ifdef CPU_HATCH_CHECKSUM_EN
      chk("ld_checksum", bus.ld_checksum, sum);
`endif
   endtask
   task automatic rd(input logic [31:0] a, input logic [47:0] exp, input string tag);
      bus.hatch_address = a;
      @(negedge clk);
      chk(tag, bus.hatch_instruction, exp);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      logic [7:0] q [$];
      int a;
      bus.ld_valid = 1'b0;
      bus.ld_byte = 8'h00;
      bus.ld_last = 1'b0;
      bus.hatch_address = '0;
      repeat (3) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      chk("rst_instr", bus.hatch_instruction, 48'h0);
      chk("rst_ready", bus.ld_ready, 1);
      chk("rst_loading", bus.loading, 0);
      chk("rst_count", bus.ld_count, 0);
      chk("rst_error", bus.ld_error, 0);
      q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
      load(q, 1'b0);
      rd(32'd0, 48'h010203040506, "rd_w0");
      rd(32'd1, 48'h0A0B0C0D0E0F, "rd_w1");
      q = {};
      repeat (6) q.push_back(8'hAA);
      q.push_back(8'hBB);
      load(q, 1'b0);
      rd(32'd1, 48'hBB0000000000, "rd_pad");
      rd(32'd0, 48'hAAAAAAAAAAAA, "rd_aa");
      q = {};
      repeat (1025 * 6) q.push_back(8'($urandom));
      load(q, 1'b1);
      rd(32'h3FF, model[1023], "rd_3ff");
      rd(32'h400, 48'h0, "rd_oor");
      rd(32'h8000_0005, 48'h0, "rd_oor_hi");
      for (int i = 0; i < 8; i++) begin
         a = $urandom_range(DEPTH - 1);
         rd(a, model[a], "rd_rand");
      end
      q = {};
      repeat (5 * 6 + 3) q.push_back(8'($urandom));
      fill(q, 5);
      send(q, 1'b1, 1'b0);
      chk("mid_loading", bus.loading, 1);
      rst_b = 1'b0;
      #1;
      chk("async_loading", bus.loading, 0);
      chk("async_count", bus.ld_count, 0);
      chk("async_ready", bus.ld_ready, 1);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) rd(i, model[i], "rd_after_rst");
      q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      load(q, 1'b0);
`ifdef CPU_HATCH_CHECKSUM_EN
      chk("checksum_15", bus.ld_checksum, 8'h15);
`endif
      rd(32'd0, 48'h010203040506, "rd_reload");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_hatch.md
Name: cpu_hatch

Overview:
- Instruction-store responder for the fetch stage. It answers the fetch word address (hatch_address) with a 48-bit instruction word (hatch_instruction).
- Includes a byte-stream program loader: valid/ready handshake, assembles 6-byte words and writes them to the store.
- Sits beside the cpu at top level. The top holds the cpu in reset while `loading` is high.

Parameters:
- ADDR_W, 10, log2 of store depth in 48-bit words (1024 words).
- NOP_WORD, 48'h0, word returned for out-of-range addresses, during load, and after reset.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- hatch_address  in  32  fetch word address (instruction index, not byte address)
- hatch_instruction  out  48  registered instruction for hatch_address
- ld_valid  in  1  loader byte valid
- ld_ready  out  1  loader can accept a byte this cycle
- ld_byte  in  8  loader data byte (big-endian within word: first byte = bits 47:40)
- ld_last  in  1  marks final byte of program, qualified by ld_valid
- loading  out  1  load in progress
- ld_count  out  ADDR_W+1  words written by current/most recent load
- ld_error  out  1  sticky: partial final word or overflow in current/most recent load

Behaviour:
- Reset (async, rst_b=0):
  - Outputs: hatch_instruction=NOP_WORD, ld_ready=1, loading=0, ld_count=0, ld_error=0.
  - Internals: FSM returns to IDLE; byte counter and write pointer go to 0.
  - Store contents are not reset.
- Read path:
  - Latency is 1 cycle: hatch_instruction(t+1) = mem[hatch_address[ADDR_W-1:0]](t).
  - If hatch_address[31:ADDR_W] != 0, the next-cycle output is NOP_WORD.
  - If loading=1, the next-cycle output is NOP_WORD. There is no read/write hazard exposure.
- Byte transfer occurs on a clock edge where ld_valid && ld_ready. ld_byte and ld_last may change only after a transfer (standard valid/ready).
- FSM states:
  - IDLE: loading=0, ld_ready=1. A transfer clears ld_count and ld_error, zeroes the write pointer, captures byte 0 and goes to COLLECT.
    - If that byte carries ld_last, treat it as a partial word: go to WRITE with the last flag set.
  - COLLECT: loading=1, ld_ready=1. Each transfer shifts the byte into the word register and increments the byte counter (0..5).
    - On the 6th byte go to WRITE.
    - On ld_last before the 6th byte: zero-pad the remaining low bytes, set ld_error, go to WRITE with the last flag set.
  - WRITE: loading=1, ld_ready=0, one cycle.
    - If the write pointer < 2^ADDR_W: write mem[wptr], increment wptr and ld_count.
    - Otherwise discard the word and set ld_error (overflow).
    - Then go to IDLE if the last flag is set, else to COLLECT with byte counter 0.
- The loading 1->0 transition occurs the cycle after the final WRITE.
- ld_count saturates at 2^ADDR_W and holds after the load until the next load starts.
- Reset mid-load: assembled partial bytes are lost, words already written remain, state goes to IDLE.
- ld_valid held high with no ld_last after the store is full: every word is discarded, ld_error=1. The loader never deadlocks.

Optional Feature:
- CPU_HATCH_CHECKSUM_EN
- Defined:
  - Adds output ld_checksum[7:0], the 8-bit modular sum of all bytes transferred in the current/most recent load.
  - Cleared on the first transfer of a load and on reset, updated on every transfer including overflow-discarded bytes.
- Undefined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Package cpu_hatch_pkg: INSTR_W=48, INSTR_BYTES=6, NOP_WORD default, loader state enum {IDLE, COLLECT, WRITE}.
- Sub-module cpu_hatch_ram: 2^ADDR_W x 48, one synchronous write port, one registered read port. Read-during-write to the same address returns old data (masked by loading anyway).
- The FSM and address range check live in cpu_hatch.

Test Plan:
- Reset release, hatch_address=0 -> hatch_instruction=48'h0, ld_ready=1, loading=0.
- Load bytes 01 02 03 04 05 06 0A 0B 0C 0D 0E 0F (last on 0F), then read address 0 then 1:
  - Response: 48'h010203040506 and 48'h0A0B0C0D0E0F, each 1 cycle after the address; ld_count=2, ld_error=0.
  - ld_ready drops for exactly one cycle after each 6th byte.
- Load 7 bytes AA..(6 bytes)..BB with last on BB:
  - word1 = 48'hBB0000000000, ld_count=2, ld_error=1.
- hatch_address=32'h0000_0400 (out of range for ADDR_W=10) -> NOP_WORD; address 0x3FF -> stored word.
- Stream 1025 words with ld_valid held, random ld_valid gaps:
  - ld_count=1024, ld_error=1, word 1023 intact, no hang.
  - During the load every hatch_instruction is NOP_WORD.
- rst_b pulsed low after byte 3 of word 5 -> loading=0 immediately, words 0-4 still readable after reset, new load starts cleanly. With CPU_HATCH_CHECKSUM_EN: 01..06 load -> ld_checksum=8'h15.
